// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU core: opcodes, FSM states, flag bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDI = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_SUB = 8'h03;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [7:0] OP_OR  = 8'h05;
    localparam logic [7:0] OP_XOR = 8'h06;
    localparam logic [7:0] OP_SHL = 8'h07;
    localparam logic [7:0] OP_SHR = 8'h08;
    localparam logic [7:0] OP_JMP = 8'h09;
    localparam logic [7:0] OP_JZ  = 8'h0A;
    localparam logic [7:0] OP_JC  = 8'h0B;
    localparam logic [7:0] OP_OUT = 8'h0C;
    localparam logic [7:0] OP_HLT = 8'hFF;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/cpu_regfile.sv
// Register file: one write port, two combinational read ports, cleared by reset.
module cpu_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

    // Next register contents: hold everything, overwrite the addressed entry on a write.
    always_comb begin
        // NOTE: start from the held value so every path assigns mem_d and no latch is inferred.
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the architectural registers must read 0 after reset, so this small array is reset explicitly.
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignment keeps all flops updating together at the clock edge.
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/cpu_core_mc.sv
// Multicycle CPU core: FETCH over a req/valid handshake, single-cycle EXEC, HALT until reset.
module cpu_core_mc
    import cpu_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter int          ADDR_W   = 6,
    parameter int          NREGS    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_W-1:0]     imem_addr,
    input  logic                  imem_valid,
    input  logic [8+2*DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    output logic [7:0]            flags,
    output logic                  halted,
    output logic                  error,
    output logic [15:0]           retired
);

    localparam int IW    = 8 + 2 * DATA_W;
    localparam int IDX_W = $clog2(NREGS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [3:0]        flags_q, flags_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              req_q, req_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;
    logic [15:0]       retired_q, retired_d;

    logic [IDX_W-1:0]  rd_idx, rs_idx;
    logic [DATA_W-1:0] rd_val, rs_val;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] jump_tgt;

    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v, alu_op;

    // Register indices use only the low bits of the operand fields.
    assign rd_idx   = IDX_W'(op1_q);
    assign rs_idx   = IDX_W'(op2_q);
    assign jump_tgt = ADDR_W'(op1_q);

    cpu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst),
        .we      (rf_we),
        .waddr   (rd_idx),
        .wdata   (rf_wdata),
        .raddr_a (rd_idx),
        .raddr_b (rs_idx),
        .rdata_a (rd_val),
        .rdata_b (rs_val)
    );

    // ALU: result, carry/borrow and signed overflow for the flag-setting opcodes.
    always_comb begin
        sum     = {1'b0, rd_val} + {1'b0, rs_val};
        diff    = {1'b0, rd_val} - {1'b0, rs_val};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_op  = 1'b1;
        case (ir_q)
            OP_ADD: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
                alu_v   = (rd_val[DATA_W-1] == rs_val[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != rd_val[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = diff[DATA_W-1:0];
                alu_c   = diff[DATA_W];
                alu_v   = (rd_val[DATA_W-1] != rs_val[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != rd_val[DATA_W-1]);
            end
            OP_AND: alu_res = rd_val & rs_val;
            OP_OR:  alu_res = rd_val | rs_val;
            OP_XOR: alu_res = rd_val ^ rs_val;
            OP_SHL: begin
                alu_res = {rd_val[DATA_W-2:0], 1'b0};
                alu_c   = rd_val[DATA_W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, rd_val[DATA_W-1:1]};
                alu_c   = rd_val[0];
            end
            default: alu_op = 1'b0;
        endcase
    end

    // Next-state logic for the FETCH/EXEC/HALT sequencer and all architectural state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        flags_d     = flags_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        req_d       = req_q;
        halted_d    = halted_q;
        error_d     = error_q;
        retired_d   = retired_q;
        rf_we       = 1'b0;
        rf_wdata    = alu_res;

        case (state_q)
            FETCH: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_valid) begin
                    ir_d    = imem_rdata[IW-1 -: 8];
                    op1_d   = imem_rdata[2*DATA_W-1 -: DATA_W];
                    op2_d   = imem_rdata[DATA_W-1:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    req_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d   = FETCH;
                req_d     = 1'b1;
                retired_d = retired_q + 16'd1;
                if (alu_op) begin
                    rf_we           = 1'b1;
                    flags_d[FLAG_Z] = (alu_res == '0);
                    flags_d[FLAG_C] = alu_c;
                    flags_d[FLAG_N] = alu_res[DATA_W-1];
                    flags_d[FLAG_V] = alu_v;
                end else begin
                    case (ir_q)
                        OP_NOP: ;
                        OP_LDI: begin
                            rf_we    = 1'b1;
                            rf_wdata = op2_q;
                        end
                        OP_JMP: pc_d = jump_tgt;
                        OP_JZ:  if (flags_q[FLAG_Z]) pc_d = jump_tgt;
                        OP_JC:  if (flags_q[FLAG_C]) pc_d = jump_tgt;
                        OP_OUT: begin
                            out_data_d  = rd_val;
                            out_valid_d = 1'b1;
                        end
                        OP_HLT: begin
                            state_d  = HALT;
                            req_d    = 1'b0;
                            halted_d = 1'b1;
                        end
                        default: begin
                            state_d   = HALT;
                            req_d     = 1'b0;
                            halted_d  = 1'b1;
                            error_d   = 1'b1;
                            retired_d = retired_q;
                        end
                    endcase
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    // Sequencer and architectural registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH;
            pc_q        <= ADDR_W'(RESET_PC);
            ir_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            flags_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            req_q       <= 1'b0;
            halted_q    <= 1'b0;
            error_q     <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            flags_q     <= flags_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            req_q       <= req_d;
            halted_q    <= halted_d;
            error_q     <= error_d;
            retired_q   <= retired_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign flags     = {4'b0000, flags_q};
    assign halted    = halted_q;
    assign error     = error_q;
    assign retired   = retired_q;

endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
Parametrised multicycle CPU core that supersedes the fixed 8-bit CPU top.
- Fetches 3-field instructions {opcode, operand1, operand2} over a req/valid instruction-memory handshake that tolerates wait states.
- Executes from an NREGS-entry register file with a DATA_W-wide ALU and flags.
- Adds conditional branches, an output port, halt/illegal-opcode detection and a retired-instruction counter.
- Sits between the program RAM and the system output; the RAM is external.

Parameters:
DATA_W, 8, datapath/register/operand width (>=4)
ADDR_W, 6, program counter width
NREGS, 4, register file entries (power of 2, >=2)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address (= PC)
imem_valid  in  1  fetch data valid
imem_rdata  in  8+2*DATA_W  {opcode[7:0], op1, op2}; opcode is the MSBs
out_data  out  DATA_W  value written by OUT
out_valid  out  1  one-cycle pulse per OUT
flags  out  8  {4'b0, V, N, C, Z} (bit0 = Z)
halted  out  1  core stopped
error  out  1  stop caused by illegal opcode
retired  out  16  retired-instruction count

Behaviour:
- Reset (asynchronous, rst=0) sets the following immediately, including mid-fetch:
  - state=FETCH, PC=RESET_PC
  - all registers, flags, out_data, retired = 0
  - imem_req, out_valid, halted, error = 0
- The first imem_req rises on the first clock after rst deasserts.
- States:
  - FETCH: imem_req=1 and imem_addr=PC, both held stable until imem_valid is sampled 1. On that edge: capture IR/op1/op2, PC <= PC+1 (mod 2^ADDR_W), go to EXEC. imem_valid while imem_req=0 is ignored.
  - EXEC: one cycle. Executes the instruction, retired <= retired+1 (wraps at 16 bits), then goes to FETCH, or to HALT for HLT/illegal.
  - HALT: imem_req=0 and all state frozen. Exit only via reset.
- Throughput: one instruction per (1 + fetch wait cycles + 1) clocks. With imem_valid asserted in the same cycle as the request, that is 2 clocks per instruction.
- Operand fields: rd = op1[log2(NREGS)-1:0], rs = op2[log2(NREGS)-1:0]. Upper bits of op1/op2 are ignored when used as a register index.
- Opcodes:
  - 0x00 NOP
  - 0x01 LDI: R[rd] <= op2
  - 0x02 ADD: R[rd] <= R[rd] + R[rs]; C = carry out, V = signed overflow
  - 0x03 SUB: R[rd] <= R[rd] - R[rs]; C = borrow (1 when R[rd] < R[rs] unsigned), V = signed overflow
  - 0x04 AND, 0x05 OR, 0x06 XOR: C = 0, V = 0
  - 0x07 SHL by 1: C = msb shifted out, V = 0
  - 0x08 SHR by 1 (logical): C = lsb shifted out, V = 0
  - 0x09 JMP: PC <= op1[ADDR_W-1:0], overriding the fetch increment
  - 0x0A JZ: jump if Z=1; not taken leaves PC unchanged
  - 0x0B JC: jump if C=1; not taken leaves PC unchanged
  - 0x0C OUT: out_data <= R[rd]; out_valid = 1 for the following cycle only
  - 0xFF HLT: halted=1
  - any other opcode: halted=1, error=1, no register or flag change, and the instruction is not counted in retired
- Flags: only opcodes 0x02–0x08 update them. For those, Z = (result==0) and N = result msb. All other opcodes leave flags unchanged.
- Arithmetic is modulo 2^DATA_W. Same-register operations (rd==rs) read the old value.
- Branch targets wrap naturally within ADDR_W. A PC increment from all-ones wraps to 0.
- The register file is written only in EXEC. It has one write port and two combinational read ports.

Decomposition:
- Package cpu_pkg: opcode localparams, state enum (FETCH, EXEC, HALT), flag bit indices (FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3).
- Sub-module cpu_regfile (parameters DATA_W, NREGS): asynchronous active-low clear, 1 write port, 2 read ports.
- ALU is combinational logic inside cpu_core_mc.

Test Plan:
1. Reset: hold rst=0 for 3 clocks, then release → imem_req=1 at PC=0 on the next clock; flags=0, retired=0, halted=0.
2. Program LDI R0,5; LDI R1,3; ADD R0,R1; OUT R0; HLT with zero-wait memory →
   - out_valid pulses once with out_data=8, flags=0x00
   - halted=1, error=0, retired=5
   - 10 clocks from first request to halted.
3. LDI R0,0xFF; LDI R1,0x01; ADD R0,R1; JC 0x20 → R0=0, flags Z=1 C=1 (0x03), next imem_addr=0x20. Also cover SUB equal operands followed by JZ → branch taken.
4. Wait states: imem_valid delayed 3 cycles on every fetch → imem_req and imem_addr stay stable throughout; results match scenario 2; 2+3 clocks per instruction.
5. Opcode 0x42 at PC=2 → halted=1, error=1, registers/flags unchanged, retired=2, imem_req=0 forever after.
6. rst asserted while in FETCH with imem_req=1 → imem_req drops in the same cycle without waiting for a clock; restart from RESET_PC. Separately, NOP-fill all 64 addresses → PC wraps from 63 to 0.
